ifmap_load_tx: RTL

//  Clocked transmitter for the imem ifmap-load protocol. Drives every command imem consumes during load:

---
 rtl/ifmap_load_tx.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/ifmap_load_tx.sv
// ifmap_load_tx: transmitter for the imem ifmap-load protocol.
// A load is one LOAD_START beat, then a TIMESTEP, ADDR and DATA beat for each
// entry, and finally a LOAD_DONE beat. The command stream covers NUM_TS timesteps
// of DEPTH_I*DEPTH_I entries each. Every DATA beat carries one bit taken from a
// serial source.
// Optional feature: define IFMAP_LOAD_TX_SPIKECNT_EN to add the spike_cnt output.
// spike_cnt counts the captured '1' bits over one load.
//
// state   | meaning
// --------+------------------------------------------------------------
// S_IDLE  | waiting for start
// S_START | LOAD_START beat (payload 1)
// S_FETCH | src_ready high, waiting to capture one spike bit
// S_TS    | TIMESTEP beat (payload ts)
// S_ADDR  | ADDR beat (payload addr)
// S_DATA  | DATA beat (payload captured bit), then advance addr/ts
// S_DONE  | LOAD_DONE beat (payload 1), done pulses on acceptance
module ifmap_load_tx #(
    parameter int DEPTH_I    = 25,
    parameter int NUM_TS     = 2,
    parameter int WIDTH_addr = 12,
    parameter int WIDTH_pkt  = 33
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 src_valid,
    input  logic                 src_bit,
    output logic                 src_ready,
    output logic                 tx_valid,
    input  logic                 tx_ready,
    output logic [2:0]           tx_kind,
    output logic [WIDTH_pkt-1:0] tx_data,
    output logic                 busy,
    output logic                 done
`ifdef IFMAP_LOAD_TX_SPIKECNT_EN
    ,
    output logic [WIDTH_addr+1:0] spike_cnt
`endif
);

    localparam logic [WIDTH_addr-1:0] ADDR_LAST = WIDTH_addr'(DEPTH_I * DEPTH_I - 1);
    localparam logic [1:0]            TS_LAST   = 2'(NUM_TS);

    localparam logic [2:0] K_LOAD_START = 3'd0;
    localparam logic [2:0] K_TIMESTEP   = 3'd1;
    localparam logic [2:0] K_ADDR       = 3'd2;
    localparam logic [2:0] K_DATA       = 3'd3;
    localparam logic [2:0] K_LOAD_DONE  = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_FETCH,
        S_TS,
        S_ADDR,
        S_DATA,
        S_DONE
    } state_t;

    state_t                state;
    logic [1:0]            ts;
    logic [WIDTH_addr-1:0] addr;
    logic                  data_reg;

    logic                  beat_state;
    logic [2:0]            beat_kind;
    logic [WIDTH_pkt-1:0]  beat_data;

    // Payload of the beat belonging to the current state. It is registered onto tx_* when the beat is launched.
    always_comb begin
        beat_state = 1'b1;
        beat_kind  = K_LOAD_START;
        beat_data  = '0;
        case (state)
            S_START: begin
                beat_kind = K_LOAD_START;
                beat_data = WIDTH_pkt'(1'b1);
            end
            S_TS: begin
                beat_kind = K_TIMESTEP;
                beat_data = WIDTH_pkt'(ts);
            end
            S_ADDR: begin
                beat_kind = K_ADDR;
                beat_data = WIDTH_pkt'(addr);
            end
            S_DATA: begin
                beat_kind = K_DATA;
                beat_data = WIDTH_pkt'(data_reg);
            end
            S_DONE: begin
                beat_kind = K_LOAD_DONE;
                beat_data = WIDTH_pkt'(1'b1);
            end
            default: beat_state = 1'b0;
        endcase
    end

    // done has to appear in the acceptance cycle itself, so it is decoded from the handshake rather than registered.
    assign done = (state == S_DONE) && tx_valid && tx_ready;

    // Load sequencer. Each beat state first registers its payload. It then holds that payload until the beat is accepted.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            ts        <= 2'd1;
            addr      <= '0;
            data_reg  <= 1'b0;
            src_ready <= 1'b0;
            tx_valid  <= 1'b0;
            tx_kind   <= '0;
            tx_data   <= '0;
            busy      <= 1'b0;
`ifdef IFMAP_LOAD_TX_SPIKECNT_EN
            spike_cnt <= '0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state <= S_START;
                        busy  <= 1'b1;
`ifdef IFMAP_LOAD_TX_SPIKECNT_EN
                        spike_cnt <= '0;
`endif
                    end
                end
                S_FETCH: begin
                    if (src_valid && src_ready) begin
                        data_reg  <= src_bit;
                        src_ready <= 1'b0;
                        state     <= S_TS;
`ifdef IFMAP_LOAD_TX_SPIKECNT_EN
                        if (src_bit) spike_cnt <= spike_cnt + 1'b1;
`endif
                    end
                end
                default: begin
                    if (beat_state && !tx_valid) begin
                        tx_valid <= 1'b1;
                        tx_kind  <= beat_kind;
                        tx_data  <= beat_data;
                    end else if (beat_state && tx_ready) begin
                        tx_valid <= 1'b0;
                        case (state)
                            S_START: begin
                                state     <= S_FETCH;
                                src_ready <= 1'b1;
                            end
                            S_TS:   state <= S_ADDR;
                            S_ADDR: state <= S_DATA;
                            S_DATA: begin
                                if (addr < ADDR_LAST) begin
                                    addr      <= addr + 1'b1;
                                    state     <= S_FETCH;
                                    src_ready <= 1'b1;
                                end else if (ts < TS_LAST) begin
                                    addr      <= '0;
                                    ts        <= ts + 1'b1;
                                    state     <= S_FETCH;
                                    src_ready <= 1'b1;
                                end else begin
                                    state <= S_DONE;
                                end
                            end
                            S_DONE: begin
                                state <= S_IDLE;
                                busy  <= 1'b0;
                                ts    <= 2'd1;
                                addr  <= '0;
                            end
                            default: state <= S_IDLE;
                        endcase
                    end else if (!beat_state) begin
                        state <= S_IDLE;
                    end
                end
            endcase
        end
    end

endmodule
